digi_spi_tx: RTL
================

// Module: digi_spi_tx
// PURPOSE
//  Downstream of the multi-channel digitizer readout. Buffers the 16-bit words
//  the digitizer presents on DOUT while ZYNQ_RD_EN is high, and serializes each
//  word to the ZYNQ over an SPI-master link (mode 0, MSB first, one word per CS_n frame).
//  Pulses SPI_done back to the digitizer after each word leaves the wire.
// PARAMETERS
//  WIDTH   16  word width (digitizer DOUT width incl. 4 spare LSBs)
//  DEPTH   16  FIFO depth in words, power of 2
//  CLKDIV  2   SCLK half-period in CK50 cycles (>=1); SCLK = CK50/(2*CLKDIV)
// PORTS
//  CK50        in   1        system clock, 50 MHz; all logic on posedge
//  RST_n       in   1        reset, asynchronous assert, active-low
//  DIN         in   WIDTH    data word from digitizer DOUT
//  DIN_VALID   in   1        write strobe = digitizer ZYNQ_RD_EN_out; one word per high cycle
//  SCLK        out  1        SPI clock to ZYNQ, idles low
//  MOSI        out  1        SPI data, MSB first
//  CS_n        out  1        SPI frame select, active-low, one frame per word
//  SPI_done    out  1        1-cycle pulse per completed word
//  BUSY        out  1        high while FIFO non-empty or a frame in progress
//  OVERFLOW    out  1        sticky: write attempted while FIFO full; cleared by reset only
//  LEVEL       out  log2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (RST_n low, async): SCLK=0, MOSI=0, CS_n=1, SPI_done=0, BUSY=0,
//   OVERFLOW=0, LEVEL=0, FSM=IDLE, FIFO pointers 0. Reset mid-frame aborts it; no
//   SPI_done issued for the aborted word.
//  FIFO: DIN captured on every CK50 edge with DIN_VALID=1 and FIFO not full.
//   DIN_VALID while full: word dropped, OVERFLOW<=1, LEVEL unchanged.
//   Same-cycle write and pop on a full FIFO: the pop frees the slot and the write
//   is accepted. Pointers wrap modulo DEPTH; LEVEL uses an extra MSB to tell full from empty.
//  FSM states and transitions:
//   IDLE:  FIFO non-empty -> LOAD.
//   LOAD:  pop head into shift reg; MOSI<=bit WIDTH-1; CS_n<=0 -> SETUP.
//   SETUP: hold CLKDIV cycles (CS_n low, SCLK low) -> SHIFT.
//   SHIFT: SCLK toggles every CLKDIV cycles; ZYNQ samples on rising edge.
//          On each falling edge except the last, shift left and present the next bit.
//          Exit after the WIDTH-th falling edge (SCLK low) -> HOLD.
//   HOLD:  CLKDIV cycles, then CS_n<=1, SPI_done=1 for exactly 1 cycle -> GAP.
//   GAP:   CS_n high for CLKDIV cycles -> LOAD if FIFO non-empty, else IDLE.
//  Frame length: CLKDIV*(2*WIDTH+2) cycles with CS_n low; min spacing of CS_n
//   falling edges is CLKDIV*(2*WIDTH+3)+2 cycles.
//  Latency: DIN_VALID into an idle, empty block -> CS_n falls 2 cycles later
//   (write, IDLE->LOAD).
//  MOSI=0 whenever CS_n=1. BUSY = (LEVEL!=0) | (FSM!=IDLE).
//  Bit counter is log2(WIDTH)+1 bits and counts falling edges. CLKDIV counter
//   reloads on every state entry.
// STRUCTURE
//  Shared package/header (digi_pkg): WIDTH default 16, FSM state encoding
//   localparams, clog2 function (same definition the digitizer uses).
//  Sub-module: digi_sync_fifo (single-clock FIFO; WIDTH, DEPTH; wr_en, rd_en,
//   full, empty, level). Register-based storage; no block RAM required.
//  Top: FIFO + FSM + clock-divide counter + shift register + bit counter.
// TESTING
//  1 word, CLKDIV=2: DIN=16'hA5C0 -> CS_n low 68 cycles; MOSI sampled on 16
//    SCLK rises = 1010_0101_1100_0000; one SPI_done pulse; BUSY then low.
//  Burst of 4 consecutive DIN_VALID (16'h0010..16'h0040) -> 4 frames in order;
//    CS_n high >= 2 cycles between frames; 4 SPI_done pulses; LEVEL peaks at 3 or 4.
//  Overflow, DEPTH=16: 18 back-to-back writes while the first frame is in progress
//    -> 1 word in the shift reg, 16 in the FIFO, 1 dropped; OVERFLOW=1;
//    17 frames total.
//  Full + simultaneous pop: FIFO full, DIN_VALID on the LOAD cycle ->
//    word accepted, LEVEL stays 16, OVERFLOW stays 0.
//  Reset mid-frame: RST_n low during bit 7 of a frame -> CS_n=1, SCLK=0 within
//    the same cycle (async); no SPI_done; after release, the block idles with LEVEL=0.
//  CLKDIV=1 corner: word 16'hFFFF -> SCLK=25 MHz, 16 rises with MOSI=1,
//    frame is 34 cycles long.

Source files
------------

// File: rtl/digi_pkg.sv
// Shared definitions for the digitizer readout path: default word width,
// SPI transmitter state encoding and the common clog2 helper.
package digi_pkg;

  localparam int DIGI_WIDTH = 16;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_LOAD  = 3'd1;
  localparam logic [2:0] ENC_SETUP = 3'd2;
  localparam logic [2:0] ENC_SHIFT = 3'd3;
  localparam logic [2:0] ENC_HOLD  = 3'd4;
  localparam logic [2:0] ENC_GAP   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_LOAD  = ENC_LOAD,
    ST_SETUP = ENC_SETUP,
    ST_SHIFT = ENC_SHIFT,
    ST_HOLD  = ENC_HOLD,
    ST_GAP   = ENC_GAP
  } spi_state_e;

  // ceil(log2(value)); clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/digi_sync_fifo.sv
// Single-clock register-based FIFO. Pointers carry one extra MSB so that
// full and empty are distinguishable; a pop on a full FIFO frees the slot
// for a write in the same cycle.
module digi_sync_fifo
  import digi_pkg::*;
#(
  parameter int WIDTH = DIGI_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_we;
  logic             w_re;

  assign w_re    = rd_en & ~empty;
  assign w_we    = wr_en & (~full | w_re);
  assign level   = r_wptr - r_rptr;
  assign full    = level[AW];
  assign empty   = (r_wptr == r_rptr);
  assign rd_data = r_mem[r_rptr[AW-1:0]];

  // storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

  // pointer update, wrapping modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_we) r_wptr <= r_wptr + 1'b1;
      if (w_re) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/digi_spi_tx.sv
// Buffers digitizer words and sends each one to the ZYNQ as a mode-0,
// MSB-first SPI frame with its own CS_n assertion. SPI_done pulses once
// per word after CS_n returns high.
module digi_spi_tx
  import digi_pkg::*;
#(
  parameter int WIDTH  = DIGI_WIDTH,
  parameter int DEPTH  = 16,
  parameter int CLKDIV = 2
) (
  input  logic                  CK50,
  input  logic                  RST_n,
  input  logic [WIDTH-1:0]      DIN,
  input  logic                  DIN_VALID,
  output logic                  SCLK,
  output logic                  MOSI,
  output logic                  CS_n,
  output logic                  SPI_done,
  output logic                  BUSY,
  output logic                  OVERFLOW,
  output logic [clog2(DEPTH):0] LEVEL
);

  localparam int DIVW = clog2(CLKDIV + 1);
  localparam int BW   = clog2(WIDTH) + 1;
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLKDIV - 1);
  // the gap carries one extra cycle for the CS_n-high/SPI_done cycle
  localparam logic [DIVW-1:0] DIV_GAP  = DIVW'(CLKDIV);
  localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);

  spi_state_e       r_state;
  logic [DIVW-1:0]  r_div;
  logic [BW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_sclk;
  logic             r_cs_n;
  logic             r_done;
  logic             r_ovf;

  logic [WIDTH-1:0]        w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic [clog2(DEPTH):0]   w_level;

  assign w_pop = (r_state == ST_LOAD);

  digi_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (CK50),
    .rst_n   (RST_n),
    .wr_en   (DIN_VALID),
    .wr_data (DIN),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  assign SCLK     = r_sclk;
  assign MOSI     = r_shift[WIDTH-1];
  assign CS_n     = r_cs_n;
  assign SPI_done = r_done;
  assign OVERFLOW = r_ovf;
  assign LEVEL    = w_level;
  assign BUSY     = (w_level != '0) | (r_state != ST_IDLE);

  // sticky overflow: a write lost because the FIFO was full and not popping
  always_ff @(posedge CK50 or negedge RST_n) begin
    if (!RST_n) r_ovf <= 1'b0;
    else if (DIN_VALID && w_full && !w_pop) r_ovf <= 1'b1;
  end

  // frame sequencer; MOSI is the shift-register MSB, cleared outside frames
  always_ff @(posedge CK50 or negedge RST_n) begin
    if (!RST_n) begin
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_sclk   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_div <= DIV_HALF;
          if (!w_empty) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_shift  <= w_head;
          r_cs_n   <= 1'b0;
          r_sclk   <= 1'b0;
          r_bitcnt <= '0;
          r_div    <= DIV_HALF;
          r_state  <= ST_SETUP;
        end
        ST_SETUP: begin
          if (r_div == '0) begin
            r_div   <= DIV_HALF;
            r_state <= ST_SHIFT;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_div != '0) begin
            r_div <= r_div - 1'b1;
          end else begin
            r_div <= DIV_HALF;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // falling edge: next bit, unless this was the last one
              r_sclk   <= 1'b0;
              r_bitcnt <= r_bitcnt + 1'b1;
              if (r_bitcnt == LAST_BIT) r_state <= ST_HOLD;
              else r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            end
          end
        end
        ST_HOLD: begin
          if (r_div == '0) begin
            r_cs_n  <= 1'b1;
            r_shift <= '0;
            r_done  <= 1'b1;
            r_div   <= DIV_GAP;
            r_state <= ST_GAP;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
        ST_GAP: begin
          if (r_div == '0) begin
            r_div   <= DIV_HALF;
            r_state <= w_empty ? ST_IDLE : ST_LOAD;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
